game_flow_sequencer: RTL
========================

// Module: game_flow_sequencer
// PURPOSE
//  Top-level game flow FSM: sequences menu, get-ready countdown, play, died, level-win and
//  game-over screens. Owns the lives count and the current level; holds the level datapath
//  (bumpy, enemies, bricks) in reset whenever play is not active.
//  Screen durations are timed from the shared one_sec tick.
//  Sits between the menu/selection logic and the per-level object/collision logic.
// PARAMETERS
//  SCREEN_SEC   3  one_sec ticks each timed screen (READY/DIED/WIN/OVER) lasts; 1..15
//  START_LIVES  3  lives loaded on game start; 1..3
//  NUM_LEVELS   5  number of levels; valid lvl 0..NUM_LEVELS-1; 1..8
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  one_sec       in   1  single-clk-cycle pulse once per second, synchronous to clk
//  menu_start    in   1  single-cycle pulse: player confirmed selection in menu
//  lvl_selected  in   3  level chosen in menu, sampled on menu_start
//  bumpy_died    in   1  level pulse/level: player died (acted on only in PLAY)
//  level_comp    in   1  level finished (acted on only in PLAY)
//  menu_screen   out  1  high in MENU
//  ready_screen  out  1  high in READY
//  died_screen   out  1  high in DIED
//  win_screen    out  1  high in WIN
//  over_screen   out  1  high in OVER
//  reset_lvl     out  1  active-high hold/reset of level datapath; high in every state but PLAY
//  lvl           out  3  current level
//  lives         out  2  remaining lives
//  sec_left      out  4  countdown for display: SCREEN_SEC-sec_cnt in timed states, else 0
//  game_done     out  1  one-cycle pulse on WIN->MENU after last level
// BEHAVIOUR
//  - All outputs registered. Reset: state=MENU, menu_screen=1, reset_lvl=1, other screen
//    flags 0, lvl=0, lives=0, sec_cnt=0, sec_left=0, game_done=0.
//  - Reset mid-operation dominates all inputs; returns to MENU the next cycle.
//  - States: MENU, READY, PLAY, DIED, WIN, OVER. Screen flags are one-hot from state.
//  - sec_cnt: cleared on every state entry; +1 on each one_sec pulse in timed states.
//    Leaves timed state on the cycle after the pulse that makes sec_cnt==SCREEN_SEC.
//    A partial first second is accepted (no tick alignment).
//  - MENU: menu_start -> READY; lvl<=min(lvl_selected,NUM_LEVELS-1); lives<=START_LIVES.
//  - READY: timeout -> PLAY. reset_lvl drops to 0 the same cycle state becomes PLAY.
//  - PLAY, priority level_comp > bumpy_died (same-cycle death discarded):
//    - level_comp -> WIN.
//    - bumpy_died and lives>1 -> lives-1, DIED.
//    - bumpy_died and lives==1 -> lives=0, OVER.
//    - Held-high inputs act once: leaving PLAY asserts reset_lvl.
//  - DIED: timeout -> READY, same lvl.
//  - WIN: timeout.
//    - lvl<NUM_LEVELS-1 -> lvl+1, READY; lives kept.
//    - lvl==NUM_LEVELS-1 -> MENU, game_done=1 for one cycle; lvl unchanged.
//  - OVER: timeout -> MENU; lvl and lives hold until next menu_start.
//  - menu_start, bumpy_died, level_comp outside their states: ignored, no state change.
//  - one_sec outside timed states: ignored. No wrap: sec_cnt never exceeds SCREEN_SEC.
// CONFIGURATION
//  GAME_PAUSE_EN defined:
//    - Adds input pause_tgl (1-cycle pulse) and output paused (reset 0).
//    - In PLAY, pause_tgl flips paused. While paused: reset_lvl=1, bumpy_died and
//      level_comp ignored.
//    - paused forced 0 on any exit from PLAY.
//    - pause_tgl coincident with level_comp/bumpy_died: the event wins, pause discarded.
//  GAME_PAUSE_EN undefined: ports pause_tgl/paused absent; PLAY behaviour as above.
// TESTING
//  1. reset 1 cycle -> MENU, lvl=0, lives=0, reset_lvl=1, sec_left=0.
//  2. lvl_selected=2 + menu_start -> READY, lvl=2, lives=3, sec_left=3.
//     3 one_sec -> PLAY, reset_lvl=0.
//  3. lvl=2, PLAY: level_comp and bumpy_died same cycle -> WIN, lives=3.
//     3 ticks -> READY, lvl=3.
//  4. lives=1, PLAY: bumpy_died -> OVER, lives=0. 3 ticks -> MENU. menu_start ignored in OVER.
//  5. NUM_LEVELS=5, lvl=4: level_comp, 3 ticks -> MENU, game_done pulse exactly 1 cycle.
//     lvl_selected=7 -> lvl=4.
//  6. GAME_PAUSE_EN: pause_tgl in PLAY -> paused=1, reset_lvl=1, bumpy_died ignored.
//     pause_tgl -> paused=0. reset asserted mid-DIED -> MENU next cycle.

Source files
------------

// File: rtl/game_flow_sequencer_if.sv
// rtl/game_flow_sequencer_if.sv - menu/level events in, screen flags and game status out
// GAME_PAUSE_EN adds pause_tgl and paused.
interface game_flow_sequencer_if;
  logic       one_sec;
  logic       menu_start;
  logic [2:0] lvl_selected;
  logic       bumpy_died;
  logic       level_comp;
  logic       menu_screen;
  logic       ready_screen;
  logic       died_screen;
  logic       win_screen;
  logic       over_screen;
  logic       reset_lvl;
  logic [2:0] lvl;
  logic [1:0] lives;
  logic [3:0] sec_left;
  logic       game_done;
`ifdef GAME_PAUSE_EN
  logic       pause_tgl;
  logic       paused;
`endif

  modport master (
`ifdef GAME_PAUSE_EN
    output pause_tgl,
    input  paused,
`endif
    output one_sec, menu_start, lvl_selected, bumpy_died, level_comp,
    input  menu_screen, ready_screen, died_screen, win_screen, over_screen,
    input  reset_lvl, lvl, lives, sec_left, game_done
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    input  pause_tgl,
    output paused,
`endif
    input  one_sec, menu_start, lvl_selected, bumpy_died, level_comp,
    output menu_screen, ready_screen, died_screen, win_screen, over_screen,
    output reset_lvl, lvl, lives, sec_left, game_done
  );
endinterface

// File: rtl/game_flow_sequencer.sv
// rtl/game_flow_sequencer.sv - game flow FSM: menu, ready, play, died, win and over screens
// Optional pause in PLAY enabled by defining GAME_PAUSE_EN.
module game_flow_sequencer #(
  parameter int SCREEN_SEC  = 3,
  parameter int START_LIVES = 3,
  parameter int NUM_LEVELS  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  game_flow_sequencer_if.slave  gf
);
  typedef enum logic [2:0] {
    S_MENU, S_READY, S_PLAY, S_DIED, S_WIN, S_OVER
  } state_t;

  localparam logic [3:0] SEC_MAX  = 4'(SCREEN_SEC);
  localparam logic [2:0] LAST_LVL = 3'(NUM_LEVELS - 1);
  localparam logic [1:0] LIVES0   = 2'(START_LIVES);

  state_t     state, state_nxt;
  logic [3:0] sec_cnt, sec_cnt_nxt, sec_left_nxt;
  logic [2:0] lvl_nxt;
  logic [1:0] lives_nxt;
  logic [4:0] flags_nxt;
  logic       reset_lvl_nxt, done_nxt, timed, timeout;
  logic       paused_q, paused_nxt;

  assign timed   = (state != S_MENU) && (state != S_PLAY);
  assign timeout = (sec_cnt == SEC_MAX);

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_MENU;
      sec_cnt      <= '0;
      gf.lvl       <= '0;
      gf.lives     <= '0;
      gf.game_done <= 1'b0;
      gf.reset_lvl <= 1'b1;
      gf.sec_left  <= '0;
      {gf.over_screen, gf.win_screen, gf.died_screen,
       gf.ready_screen, gf.menu_screen} <= 5'b00001;
    end else begin
      state        <= state_nxt;
      sec_cnt      <= sec_cnt_nxt;
      gf.lvl       <= lvl_nxt;
      gf.lives     <= lives_nxt;
      gf.game_done <= done_nxt;
      gf.reset_lvl <= reset_lvl_nxt;
      gf.sec_left  <= sec_left_nxt;
      {gf.over_screen, gf.win_screen, gf.died_screen,
       gf.ready_screen, gf.menu_screen} <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lvl_nxt   = gf.lvl;
    lives_nxt = gf.lives;
    done_nxt  = 1'b0;
    case (state)
      S_MENU: if (gf.menu_start) begin
        state_nxt = S_READY;
        lvl_nxt   = (gf.lvl_selected > LAST_LVL) ? LAST_LVL : gf.lvl_selected;
        lives_nxt = LIVES0;
      end
      S_READY: if (timeout) state_nxt = S_PLAY;
      // level_comp outranks a same-cycle death; events are frozen while paused.
      S_PLAY: if (!paused_q) begin
        if (gf.level_comp) begin
          state_nxt = S_WIN;
        end else if (gf.bumpy_died) begin
          lives_nxt = gf.lives - 2'd1;
          state_nxt = (gf.lives > 2'd1) ? S_DIED : S_OVER;
        end
      end
      S_DIED: if (timeout) state_nxt = S_READY;
      S_WIN: if (timeout) begin
        if (gf.lvl < LAST_LVL) begin
          lvl_nxt   = gf.lvl + 3'd1;
          state_nxt = S_READY;
        end else begin
          state_nxt = S_MENU;
          done_nxt  = 1'b1;
        end
      end
      S_OVER: if (timeout) state_nxt = S_MENU;
      default: state_nxt = S_MENU;
    endcase

    sec_cnt_nxt = sec_cnt;
    if (state_nxt != state)
      sec_cnt_nxt = '0;
    else if (timed && gf.one_sec && !timeout)
      sec_cnt_nxt = sec_cnt + 4'd1;
  end

  always_comb begin
    flags_nxt    = '0;
    sec_left_nxt = '0;
    case (state_nxt)
      S_MENU:  flags_nxt[0] = 1'b1;
      S_READY: flags_nxt[1] = 1'b1;
      S_DIED:  flags_nxt[2] = 1'b1;
      S_WIN:   flags_nxt[3] = 1'b1;
      S_OVER:  flags_nxt[4] = 1'b1;
      default: flags_nxt    = '0;
    endcase
    if (state_nxt != S_MENU && state_nxt != S_PLAY)
      sec_left_nxt = SEC_MAX - sec_cnt_nxt;
    reset_lvl_nxt = (state_nxt != S_PLAY) || paused_nxt;
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset) paused_q <= 1'b0;
    else       paused_q <= paused_nxt;
  end

  // A same-cycle event leaves PLAY, which both clears paused and drops the toggle.
  always_comb begin
    paused_nxt = 1'b0;
    if (state == S_PLAY && state_nxt == S_PLAY)
      paused_nxt = paused_q ^ gf.pause_tgl;
  end

  assign gf.paused = paused_q;
`else
  assign paused_q   = 1'b0;
  assign paused_nxt = 1'b0;
`endif
endmodule
